alu_seq: RTL and testbench

- Command-driven sequencer sitting in front of the 16-bit combinational ALU (control bits zx, nx, zy, ny, f, no).
- Accepts an opcode plus two operands over a valid/ready handshake and drives the ALU control bits and operands.
- Single-step ops complete in one ALU pass. Shift-left and multiply are iterated over several ALU passes.
- Returns the 16-bit result and flags over a second valid/ready handshake.

---
 rtl/alu_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: command sequencer in front of a 16-bit zx/nx/zy/ny/f/no ALU.
// Accepts {op, A, B} on a valid/ready handshake, drives the external ALU
// for one or more passes and returns {data, zr, ng, err} on a second
// valid/ready handshake. Ops 0-7 are single pass; op 8 (SHL) iterates
// doublings; op 9 (MUL) is shift-add and exists only when the macro
// ALU_SEQ_MUL_EN is defined (otherwise op 9 reports an illegal opcode).
// An SHL with a non-zero count goes straight from IDLE to LOOP_DBL so
// that a count of k returns after k+1 cycles.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zr,
  output logic         rsp_ng,
  output logic         rsp_err,
  output logic         alu_zx,
  output logic         alu_nx,
  output logic         alu_zy,
  output logic         alu_ny,
  output logic         alu_f,
  output logic         alu_no,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  input  logic [W-1:0] alu_out
);

  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  // Control words, ordered {zx, nx, zy, ny, f, no}.
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_PASS = 6'b001100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
`ifdef ALU_SEQ_MUL_EN
    S_LOOP_ADD,
`endif
    S_LOOP_DBL,
    S_RESP
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] acc_q, acc_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_zr_q, rsp_zr_d;
  logic         rsp_ng_q, rsp_ng_d;
  logic         rsp_err_q, rsp_err_d;

  logic [5:0]   ctrl;
  logic         res_load;
  logic [W-1:0] res_val;
  logic         res_err;

  // Control word for the eight single-pass opcodes.
  function automatic logic [5:0] single_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    single_ctrl = 6'b000010; // x + y
      3'd1:    single_ctrl = 6'b010011; // x - y
      3'd2:    single_ctrl = 6'b000000; // x & y
      3'd3:    single_ctrl = 6'b010101; // x | y
      3'd4:    single_ctrl = 6'b001101; // ~x
      3'd5:    single_ctrl = 6'b001111; // -x
      3'd6:    single_ctrl = 6'b011111; // x + 1
      default: single_ctrl = 6'b001110; // x - 1
    endcase
  endfunction

  // Next-state, datapath updates and ALU drive for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    m_d         = m_q;
    n_d         = n_q;
    acc_d       = acc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zr_d    = rsp_zr_q;
    rsp_ng_d    = rsp_ng_q;
    rsp_err_d   = rsp_err_q;
    ctrl        = 6'b000000;
    alu_x       = '0;
    alu_y       = '0;
    res_load    = 1'b0;
    res_val     = '0;
    res_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          m_d   = cmd_a;
          n_d   = cmd_b;
          acc_d = '0;
          if (cmd_op == OP_SHL) begin
            n_d     = W'(cmd_b[3:0]);
            state_d = (cmd_b[3:0] != 4'd0) ? S_LOOP_DBL : S_EXEC;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (op_q < OP_SHL) begin
          ctrl     = single_ctrl(op_q[2:0]);
          alu_x    = m_q;
          alu_y    = n_q;
          res_load = 1'b1;
          res_val  = alu_out;
        end else if (op_q == OP_SHL) begin
          // Zero shift count: pass A straight through the ALU.
          ctrl     = CTRL_PASS;
          alu_x    = m_q;
          res_load = 1'b1;
          res_val  = alu_out;
`ifdef ALU_SEQ_MUL_EN
        end else if (op_q == OP_MUL) begin
          // Multiplier exhausted: the accumulator holds the product.
          if (n_q == '0) begin
            res_load = 1'b1;
            res_val  = acc_q;
          end else if (n_q[0]) begin
            state_d = S_LOOP_ADD;
          end else begin
            state_d = S_LOOP_DBL;
          end
`else
        end else if (op_q == OP_MUL) begin
          res_load = 1'b1;
          res_err  = 1'b1;
`endif
        end else begin
          res_load = 1'b1;
          res_err  = 1'b1;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      S_LOOP_ADD: begin
        ctrl    = CTRL_ADD;
        alu_x   = acc_q;
        alu_y   = m_q;
        acc_d   = alu_out;
        state_d = S_LOOP_DBL;
      end
`endif

      S_LOOP_DBL: begin
        ctrl  = CTRL_ADD;
        alu_x = m_q;
        alu_y = m_q;
        m_d   = alu_out;
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          n_d     = n_q >> 1;
          state_d = S_EXEC;
        end else
`endif
        begin
          n_d = n_q - W'(1);
          if (n_q == W'(1)) begin
            res_load = 1'b1;
            res_val  = alu_out;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Capture the result and its flags together so they stay coherent in RESP.
    if (res_load) begin
      rsp_data_d  = res_val;
      rsp_zr_d    = (res_val == '0);
      rsp_ng_d    = res_val[W-1];
      rsp_err_d   = res_err;
      rsp_valid_d = 1'b1;
      state_d     = S_RESP;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      m_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zr_q    <= 1'b0;
      rsp_ng_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      m_q         <= m_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zr_q    <= rsp_zr_d;
      rsp_ng_q    <= rsp_ng_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the external ALU.
// Checks reset state, every single-pass op, SHL counts, MUL (or its
// illegal-op behaviour when ALU_SEQ_MUL_EN is undefined), backpressure,
// illegal opcodes and reset in the middle of an iterated operation.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zr;
  logic         rsp_ng;
  logic         rsp_err;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [W-1:0] alu_out;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zr    (rsp_zr),
    .rsp_ng    (rsp_ng),
    .rsp_err   (rsp_err),
    .alu_zx    (alu_zx),
    .alu_nx    (alu_nx),
    .alu_zy    (alu_zy),
    .alu_ny    (alu_ny),
    .alu_f     (alu_f),
    .alu_no    (alu_no),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out)
  );

  // Behavioural model of the combinational ALU the sequencer drives.
  function automatic logic [W-1:0] hack_alu(input logic zx, nx, zy, ny, f, no,
                                            input logic [W-1:0] x, y);
    logic [W-1:0] xx, yy, oo;
    xx = zx ? '0 : x;
    xx = nx ? ~xx : xx;
    yy = zy ? '0 : y;
    yy = ny ? ~yy : yy;
    oo = f ? xx + yy : xx & yy;
    return no ? ~oo : oo;
  endfunction

  assign alu_out = hack_alu(alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] alu_idle_bits();
    return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, |alu_x, |alu_y};
  endfunction

  // Issue one command, measure accept-to-rsp_valid latency and check the
  // response. exp_lat of 0 skips the latency check. With rsp_ready high the
  // handshake and the return of cmd_ready are checked too.
  task automatic run(input string tag, input logic [3:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_data, input logic exp_err,
                     input int exp_lat);
    int waited;
    int lat;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) return;
    check({tag, " idle alu drive"}, 32'(alu_idle_bits()), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
    cmd_a     = 16'hDEAD;
    cmd_b     = 16'hBEEF;
    cmd_op    = 4'd0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid !== 1'b1) return;
    if (exp_lat > 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, " zr"}, 32'(rsp_zr), 32'(exp_data == 16'h0000));
    check({tag, " ng"}, 32'(rsp_ng), 32'(exp_data[15]));
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    if (rsp_ready) begin
      step();
      check({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
      check({tag, " cmd_ready after handshake"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    logic stale;
    logic busy_accept;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;

    // Reset state.
    #2;
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", 32'(rsp_data), 32'd0);
    check("reset flags", 32'({rsp_zr, rsp_ng, rsp_err}), 32'd0);
    check("reset alu drive", 32'(alu_idle_bits()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    check("cmd_ready before first edge", 32'(cmd_ready), 32'd0);
    step();
    check("cmd_ready first edge", 32'(cmd_ready), 32'd1);

    // Single-pass ops.
    run("add",  4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 2);
    run("sub",  4'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 2);
    run("neg0", 4'd5, 16'h0000, 16'h1111, 16'h0000, 1'b0, 2);
    run("neg",  4'd5, 16'h0003, 16'h0000, 16'hFFFD, 1'b0, 2);
    run("and",  4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 2);
    run("or",   4'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2);
    run("not",  4'd4, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 2);
    run("inc",  4'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2);
    run("dec",  4'd7, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 2);

    // Shift left: latency count+1, count 0 passes A, count uses only B[3:0].
    run("shl4",   4'd8, 16'h0001, 16'h0004, 16'h0010, 1'b0, 5);
    run("shl0",   4'd8, 16'h1234, 16'h0000, 16'h1234, 1'b0, 2);
    run("shl1",   4'd8, 16'h8001, 16'h0001, 16'h0002, 1'b0, 2);
    run("shl_hi", 4'd8, 16'h0003, 16'hFFF2, 16'h000C, 1'b0, 3);

`ifdef ALU_SEQ_MUL_EN
    run("mul",      4'd9, 16'd300,  16'd7,    16'h0834, 1'b0, 0);
    run("mul_zr",   4'd9, 16'h0100, 16'h0100, 16'h0000, 1'b0, 0);
    run("mul_b0",   4'd9, 16'h0005, 16'h0000, 16'h0000, 1'b0, 2);
    run("mul_wrap", 4'd9, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 0);
`else
    run("mul_off",  4'd9, 16'd300,  16'd7,    16'h0000, 1'b1, 2);
`endif

    run("illegal12", 4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b1, 2);
    run("illegal15", 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2);

    // Backpressure: response held for three cycles, busy command ignored.
    rsp_ready = 1'b0;
    run("bp", 4'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2);
    cmd_valid = 1'b1;
    cmd_op    = 4'd0;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      cmd_valid = 1'b0;
      check("bp held valid", 32'(rsp_valid), 32'd1);
      check("bp held data", 32'(rsp_data), 32'h0FF0);
      check("bp held flags", 32'({rsp_zr, rsp_ng, rsp_err}), 32'd0);
      check("bp cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp release cmd_ready", 32'(cmd_ready), 32'd1);
    busy_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) busy_accept = 1'b1;
    end
    check("bp busy command ignored", 32'(busy_accept), 32'd0);

    // Reset in the middle of an iterated operation.
    cmd_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    cmd_op = 4'd9;
    cmd_a  = 16'h1234;
    cmd_b  = 16'hFFFF;
`else
    cmd_op = 4'd8;
    cmd_a  = 16'h0001;
    cmd_b  = 16'h000F;
`endif
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("midop still busy", 32'(cmd_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midop rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("midop rst data", 32'(rsp_data), 32'd0);
    check("midop rst alu drive", 32'(alu_idle_bits()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    check("midop cmd_ready before edge", 32'(cmd_ready), 32'd0);
    step();
    check("midop cmd_ready after edge", 32'(cmd_ready), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rsp_valid !== 1'b0) stale = 1'b1;
    end
    check("midop no stale response", 32'(stale), 32'd0);

    run("post_reset add", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
